// File: rtl/tiny_shader_pkg.sv
// Shared definitions for the tiny shader host interface: SPI command bytes
// and the command FSM state encoding.
package tiny_shader_pkg;

  localparam logic [7:0] CMD_WRITE_MEM = 8'h00;
  localparam logic [7:0] CMD_WRITE_REG = 8'h01;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    MEM    = 3'd2,
    RADDR  = 3'd3,
    RDATA  = 3'd4,
    IGNORE = 3'd5
  } spi_state_t;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous inputs. RST_VAL lets each bit come
// out of reset at its idle level (e.g. an active-low chip select resets high).
module synchronizer #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] ff1_q;
  logic [WIDTH-1:0] ff2_q;

  // Two back-to-back flops give metastability time to resolve.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff1_q <= RST_VAL;
      ff2_q <= RST_VAL;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/spi_receiver.sv
// SPI mode-1 responder: oversamples SCLK/MOSI/CS in the clk_i domain,
// assembles MSB-first bytes and decodes them into single-cycle write strobes
// for shader memory and parameter registers.
//
// Strobe semantics: mem_we_o / reg_we_o are one-cycle pulses with no
// back-pressure; the matching addr/wdata outputs are valid in the strobe cycle
// and hold their last value otherwise.
module spi_receiver
  import tiny_shader_pkg::*;
#(
  parameter int MEM_DEPTH = 8,
  parameter int REG_COUNT = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         spi_sclk_i,
  input  logic                         spi_mosi_i,
  input  logic                         spi_cs_ni,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  output logic [7:0]                   mem_wdata_o,
  output logic                         reg_we_o,
  output logic [$clog2(REG_COUNT)-1:0] reg_addr_o,
  output logic [7:0]                   reg_wdata_o,
  output logic                         busy_o
);

  localparam int MAW = $clog2(MEM_DEPTH);
  localparam int RAW = $clog2(REG_COUNT);

  // ---------------------------------------------------------------------------
  // Input synchronization and falling-edge detection
  // ---------------------------------------------------------------------------
  logic sclk_s, mosi_s, cs_s;
  logic sclk_q;
  logic sample_edge;

  synchronizer #(
    .WIDTH  (3),
    .RST_VAL(3'b100)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   ({spi_cs_ni, spi_mosi_i, spi_sclk_i}),
    .q_o   ({cs_s, mosi_s, sclk_s})
  );

  // History flop on synced SCLK for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sclk_q <= 1'b0;
    else         sclk_q <= sclk_s;
  end

  assign sample_edge = sclk_q & ~sclk_s;

  // ---------------------------------------------------------------------------
  // Byte assembly: 7 stored bits plus the bit arriving on the 8th edge
  // ---------------------------------------------------------------------------
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_valid_q;
  logic [7:0] byte_q;

  // Shift on sample edges while selected; CS high discards any partial byte
  // and takes priority over a coincident sample edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
    end else if (cs_s) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
    end else if (sample_edge) begin
      shift_q      <= {shift_q[5:0], mosi_s};
      bit_cnt_q    <= bit_cnt_q + 3'd1;
      byte_valid_q <= (bit_cnt_q == 3'd7);
      if (bit_cnt_q == 3'd7) byte_q <= {shift_q, mosi_s};
    end else begin
      byte_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM with registered outputs
  // ---------------------------------------------------------------------------
  spi_state_t         state_q, state_d;
  logic [MAW-1:0]     mem_ptr_q, mem_ptr_d;
  logic [RAW-1:0]     reg_ptr_q, reg_ptr_d;
  logic               mem_we_d, reg_we_d;
  logic [MAW-1:0]     mem_addr_d;
  logic [RAW-1:0]     reg_addr_d;
  logic [7:0]         mem_wdata_d, reg_wdata_d;

  // State, pointers and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mem_ptr_q   <= '0;
      reg_ptr_q   <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      mem_ptr_q   <= mem_ptr_d;
      reg_ptr_q   <= reg_ptr_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      reg_we_o    <= reg_we_d;
      reg_addr_o  <= reg_addr_d;
      reg_wdata_o <= reg_wdata_d;
    end
  end

  // Next-state decode: one action per assembled byte; CS high forces IDLE.
  always_comb begin
    state_d     = state_q;
    mem_ptr_d   = mem_ptr_q;
    reg_ptr_d   = reg_ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_o;
    reg_wdata_d = reg_wdata_o;

    if (cs_s) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (byte_valid_q) begin
            case (byte_q)
              CMD_WRITE_MEM: begin
                state_d   = MEM;
                mem_ptr_d = '0;
              end
              CMD_WRITE_REG: state_d = RADDR;
              default:       state_d = IGNORE;
            endcase
          end
        end
        MEM: begin
          if (byte_valid_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = mem_ptr_q;
            mem_wdata_d = byte_q;
            // No wrap: the last slot ends the burst.
            if (mem_ptr_q == MAW'(MEM_DEPTH - 1)) state_d = IGNORE;
            else                                   mem_ptr_d = mem_ptr_q + 1'b1;
          end
        end
        RADDR: begin
          if (byte_valid_q) begin
            if (int'(byte_q) < REG_COUNT) begin
              reg_ptr_d = byte_q[RAW-1:0];
              state_d   = RDATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        RDATA: begin
          if (byte_valid_q) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = reg_ptr_q;
            reg_wdata_d = byte_q;
            if (reg_ptr_q == RAW'(REG_COUNT - 1)) state_d = IGNORE;
            else                                   reg_ptr_d = reg_ptr_q + 1'b1;
          end
        end
        IGNORE: state_d = IGNORE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE) & ~cs_s;

endmodule

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver: scenario tasks drive SPI traffic and
// push expected writes; a negedge monitor pops and compares every strobe.
module tb_spi_receiver;

  localparam int HALF = 20;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Entry: {is_reg, addr[2:0], data[7:0]}
  logic [11:0] exp_q[$];

  spi_receiver #(
    .MEM_DEPTH(8),
    .REG_COUNT(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .spi_sclk_i (sclk),
    .spi_mosi_i (mosi),
    .spi_cs_ni  (cs_n),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .reg_we_o   (reg_we),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .busy_o     (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  logic        prev_strobe = 1'b0;
  logic [11:0] obs;
  logic [11:0] exp_v;

  always @(negedge clk) begin
    if (rst_n && (mem_we || reg_we)) begin
      checks++;
      if (mem_we && reg_we) begin
        failures++;
        $display("FAIL dual_strobe: mem_we=%0b reg_we=%0b, required only one", mem_we, reg_we);
      end
      checks++;
      if (prev_strobe) begin
        failures++;
        $display("FAIL strobe_width: strobe in consecutive cycles, required a gap");
      end
      obs = mem_we ? {1'b0, mem_addr, mem_wdata} : {1'b1, 1'b0, reg_addr, reg_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got %h, required no strobe", obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL strobe_data: got %h, required %h", obs, exp_v);
        end
      end
    end
    prev_strobe = rst_n && (mem_we || reg_we);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push_mem(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, a, d});
  endtask

  task automatic push_reg(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, 1'b0, a, d});
  endtask

  task automatic spi_bit(input logic b, input int half);
    sclk = 1'b1;
    mosi = b;
    #(half);
    sclk = 1'b0;
    #(half);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], HALF);
  endtask

  task automatic cs_low;
    cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_high(input int hold);
    #(HALF);
    cs_n = 1'b1;
    #(hold);
  endtask

  task automatic drain(input string name);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing: %0d strobes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_after: busy=%b, required 0", name, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    #23;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata, busy});
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || reg_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b mem_we=%b reg_we=%b, required 0", busy, mem_we, reg_we);
    end
  endtask

  task automatic test_mem_write;
    cs_low();
    spi_byte(8'h00);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mem_busy_during: busy=%b, required 1", busy);
    end
    push_mem(3'd0, 8'hA1); spi_byte(8'hA1);
    push_mem(3'd1, 8'hB2); spi_byte(8'hB2);
    push_mem(3'd2, 8'hC3); spi_byte(8'hC3);
    cs_high(40);
    drain("mem_write");
  endtask

  task automatic test_mem_overflow;
    logic [7:0] d;
    cs_low();
    spi_byte(8'h00);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 8) push_mem(3'(i), d);
      spi_byte(d);
    end
    cs_high(40);
    drain("mem_overflow");
  endtask

  task automatic test_reg_write;
    cs_low();
    spi_byte(8'h01);
    spi_byte(8'h02);
    push_reg(2'd2, 8'h55); spi_byte(8'h55);
    push_reg(2'd3, 8'h66); spi_byte(8'h66);
    spi_byte(8'h77);
    cs_high(40);
    drain("reg_write");
    cs_low();
    spi_byte(8'h01);
    spi_byte(8'h07);
    spi_byte(8'h11);
    cs_high(40);
    drain("reg_bad_addr");
  endtask

  task automatic test_abort;
    logic [7:0] pat;
    pat = 8'hE5;
    cs_low();
    spi_byte(8'h00);
    for (int i = 7; i >= 3; i--) spi_bit(pat[i], HALF);
    cs_high(40);
    drain("abort");
    cs_low();
    spi_byte(8'h00);
    push_mem(3'd0, 8'h3C); spi_byte(8'h3C);
    cs_high(40);
    drain("abort_recover");
  endtask

  task automatic test_unknown_cmd;
    cs_low();
    spi_byte(8'h7F);
    spi_byte(8'h12);
    spi_byte(8'h34);
    cs_high(40);
    drain("unknown_cmd");
  endtask

  task automatic test_timing;
    logic [7:0] d;
    int ph;
    for (int r = 0; r < 3; r++) begin
      d  = 8'($urandom_range(0, 255));
      ph = $urandom_range(1, 9);
      cs_low();
      spi_byte(8'h00);
      push_mem(3'd0, d);
      @(posedge clk);
      #(ph);
      for (int i = 7; i >= 1; i--) spi_bit(d[i], HALF);
      sclk = 1'b1;
      mosi = d[0];
      #(HALF);
      sclk = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk);
        #1;
        checks++;
        if (mem_we !== (k == 4)) begin
          failures++;
          $display("FAIL timing_latency: cycle %0d phase %0d mem_we=%b, required %b",
                   k, ph, mem_we, (k == 4));
        end
      end
      cs_high(40);
      drain("timing");
    end
  endtask

  task automatic test_reset_mid;
    cs_low();
    spi_byte(8'h00);
    push_mem(3'd0, 8'h5A); spi_byte(8'h5A);
    push_mem(3'd1, 8'h6B); spi_byte(8'h6B);
    spi_bit(1'b1, HALF);
    spi_bit(1'b0, HALF);
    spi_bit(1'b1, HALF);
    sclk = 1'b1;
    #7;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h, required 0",
               {mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata, busy});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_pending: %0d strobes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    sclk = 1'b0;
    cs_n = 1'b1;
    #30;
    rst_n = 1'b1;
    #30;
    cs_low();
    spi_byte(8'h00);
    push_mem(3'd0, 8'hC7); spi_byte(8'hC7);
    cs_high(40);
    drain("reset_mid_recover");
  endtask

  task automatic test_back_to_back;
    logic [7:0] d0, d1;
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    cs_low();
    spi_byte(8'h00);
    push_mem(3'd0, d0); spi_byte(d0);
    cs_high(30);
    cs_low();
    spi_byte(8'h01);
    spi_byte(8'h00);
    push_reg(2'd0, d1); spi_byte(d1);
    cs_high(40);
    drain("back_to_back");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_mem_write();
    test_mem_overflow();
    test_reg_write();
    test_abort();
    test_unknown_cmd();
    test_timing();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
